// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default bit divider and
// frame shape (8 data bits, 1 stop bit) common to the transmitter and receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam int DEFAULT_DIVIDER = 434;  // 50 MHz / 434 ~= 115200 baud
  localparam int DATA_BITS       = 8;
  localparam int STOP_BITS       = 1;
  localparam int TIMER_W         = 9;    // holds DIVIDER-1 for DIVIDER up to 511
  localparam int INDEX_W         = 3;    // counts data bits 0..7

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line. Both stages come out
// of reset high so that a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic rxs
);

  logic meta;

  // Capture the raw line and re-register it to settle metastability.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its source; blocking here would collapse the chain.
    if (rst) begin
      meta <= 1'b1;
      rxs  <= 1'b1;
    end else begin
      meta <= line;
      rxs  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. A restartable bit timer is loaded on the start edge and
// reloaded on every sample point, so timing error never accumulates.
// Optional macro UART_RX_MAJORITY_EN: each sample point takes the 2-of-3
// majority of rxs around it, which moves every decision and pulse one cycle later.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DIVIDER = DEFAULT_DIVIDER
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_PIN,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_ERR,
  output logic       RX_BUSY
);

  localparam logic [TIMER_W-1:0] BIT_LOAD   = TIMER_W'(DIVIDER - 1);
  localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(DATA_BITS - 1);

  rx_state_e              state, state_d;
  logic [TIMER_W-1:0]     timer, timer_d;
  logic [INDEX_W-1:0]     index, index_d;
  logic [DATA_BITS-1:0]   shift, shift_d, data_d;
  logic                   valid_d, err_d;
  logic                   rxs;
  logic                   bit_val;
  logic                   timer_zero;

  uart_rx_sync u_sync (
    .clk  (CLK),
    .rst  (RST),
    .line (RX_PIN),
    .rxs  (rxs)
  );

`ifdef UART_RX_MAJORITY_EN
  // First sample lands one cycle late so rxs at sample+1 is available.
  localparam logic [TIMER_W-1:0] START_LOAD = TIMER_W'(DIVIDER / 2);

  logic [1:0] hist;

  // History of rxs: hist[0] is one cycle old, hist[1] two cycles old.
  always_ff @(posedge CLK) begin
    if (RST) hist <= 2'b11;
    else     hist <= {hist[0], rxs};
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rxs) | (hist[0] & rxs);
`else
  localparam logic [TIMER_W-1:0] START_LOAD = TIMER_W'(DIVIDER / 2 - 1);

  assign bit_val = rxs;
`endif

  assign timer_zero = (timer == '0);
  assign RX_BUSY    = (state != IDLE);

  // Next-state, timer, bit index, shift register and output pulse decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block free of latches.
    state_d = state;
    timer_d = timer;
    index_d = index;
    shift_d = shift;
    data_d  = RX_DATA;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          timer_d = START_LOAD;
        end
      end
      START: begin
        if (!timer_zero) begin
          timer_d = timer - 1'b1;
        end else if (!bit_val) begin
          state_d = DATA;
          index_d = '0;
          timer_d = BIT_LOAD;
        end else begin
          state_d = IDLE;  // glitch shorter than half a bit: ignore silently
        end
      end
      DATA: begin
        if (!timer_zero) begin
          timer_d = timer - 1'b1;
        end else begin
          shift_d = {bit_val, shift[DATA_BITS-1:1]};
          timer_d = BIT_LOAD;
          if (index == LAST_INDEX) state_d = STOP;
          else                     index_d = index + 1'b1;
        end
      end
      STOP: begin
        if (!timer_zero) begin
          timer_d = timer - 1'b1;
        end else if (bit_val) begin
          data_d  = shift;
          valid_d = 1'b1;
          state_d = IDLE;  // re-armed at once for back-to-back frames
        end else begin
          err_d   = 1'b1;
          state_d = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rxs) state_d = IDLE;  // a held break yields a single error pulse
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: the shift register and RX_DATA are reset along with the control
    // state, so a reset mid-frame leaves no stale partial byte behind.
    if (RST) begin
      state    <= IDLE;
      timer    <= '0;
      index    <= '0;
      shift    <= '0;
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
      RX_ERR   <= 1'b0;
    end else begin
      state    <= state_d;
      timer    <= timer_d;
      index    <= index_d;
      shift    <= shift_d;
      RX_DATA  <= data_d;
      RX_VALID <= valid_d;
      RX_ERR   <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. A frame-level model predicts, for every
// frame the bench sends, the cycle and kind of pulse it must produce; a
// compare process checks all outputs every cycle. A second instance with a
// short divider receives a full 0x00..0xFF sweep.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int D  = 434;
  localparam int FD = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Start bit driven before clock edge c+1: two synchronizer stages, half a
  // bit to the start sample, then 8 data bits and the stop bit a bit apart,
  // then one register stage for the pulse.
  localparam int LAT = 3 + D / 2 + (DATA_BITS + STOP_BITS) * D + MAJ;

  typedef struct {
    int         cyc;
    bit         err;
    logic [7:0] data;
  } ev_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_PIN = 1'b1;
  logic [7:0] RX_DATA;
  logic       RX_VALID, RX_ERR, RX_BUSY;
  logic       fast_pin = 1'b1;
  logic [7:0] f_data;
  logic       f_valid, f_err, f_busy;

  uart_rx #(.DIVIDER(D)) dut (
    .CLK(CLK), .RST(RST), .RX_PIN(RX_PIN),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_ERR(RX_ERR), .RX_BUSY(RX_BUSY)
  );

  uart_rx #(.DIVIDER(FD)) u_fast (
    .CLK(CLK), .RST(RST), .RX_PIN(fast_pin),
    .RX_DATA(f_data), .RX_VALID(f_valid), .RX_ERR(f_err), .RX_BUSY(f_busy)
  );

  always #5 CLK = ~CLK;

  int   cyc = 0;
  logic rst_at_edge = 1'b1;
  always @(posedge CLK) begin
    cyc         <= cyc + 1;
    rst_at_edge <= RST;
  end

  int         checks = 0;
  int         errors = 0;
  ev_t        exp_q[$];
  logic [7:0] model_data = 8'h00;
  int         n_valid = 0, n_err = 0;
  int         last_valid_cyc = 0, prev_valid_cyc = 0;
  logic [7:0] fast_q[$];
  int         f_n = 0, f_nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of the main instance against the frame model.
  always @(negedge CLK) begin
    bit  ev_valid, ev_err;
    ev_t ev;
    ev_valid = 1'b0;
    ev_err   = 1'b0;
    if (rst_at_edge) begin
      exp_q.delete();
      model_data = 8'h00;
      check("busy_in_reset", 32'(RX_BUSY), 32'(0));
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      ev = exp_q.pop_front();
      if (ev.cyc == cyc) begin
        if (ev.err) ev_err = 1'b1;
        else begin
          ev_valid   = 1'b1;
          model_data = ev.data;
        end
      end
    end
    check("rx_valid", 32'(RX_VALID), 32'(ev_valid));
    check("rx_err", 32'(RX_ERR), 32'(ev_err));
    check("rx_data", 32'(RX_DATA), 32'(model_data));
    if (ev_valid) check("busy_after_stop", 32'(RX_BUSY), 32'(0));
    if (ev_err)   check("busy_wait_high", 32'(RX_BUSY), 32'(1));
    if (RX_VALID === 1'b1) begin
      n_valid++;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
    end
    if (RX_ERR === 1'b1) n_err++;
  end

  // Scoreboard for the short-divider sweep instance.
  always @(negedge CLK) begin
    if (f_valid === 1'b1) begin
      f_n++;
      if (fast_q.size() == 0) check("fast_unexpected", 32'(f_data), 32'hFFFF_FFFF);
      else                    check("fast_data", 32'(f_data), 32'(fast_q.pop_front()));
    end
    if (f_err === 1'b1) f_nerr++;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Drive one frame on RX_PIN starting at the current falling edge and log
  // the pulse it must produce. A bad frame holds the stop bit low for
  // stop_len cycles, then returns the line high for one bit time.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok,
                            input int stop_len, output int start_cyc);
    ev_t ev;
    start_cyc = cyc;
    ev.cyc    = cyc + LAT;
    ev.err    = !stop_ok;
    ev.data   = b;
    exp_q.push_back(ev);
    RX_PIN = 1'b0;
    hold(D);
    for (int i = 0; i < 8; i++) begin
      RX_PIN = b[i];
      hold(D);
    end
    if (stop_ok) begin
      RX_PIN = 1'b1;
      hold(D);
    end else begin
      RX_PIN = 1'b0;
      hold(stop_len);
      RX_PIN = 1'b1;
      hold(D);
    end
  endtask

  // Frame on the fast instance; with majority voting, the middle sample of
  // every bit is inverted for one cycle and must be outvoted.
  task automatic send_fast(input logic [7:0] b);
    logic v;
    fast_q.push_back(b);
    for (int slot = 0; slot < 10; slot++) begin
      v = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : b[slot-1];
      for (int k = 0; k < FD; k++) begin
        fast_pin = (MAJ == 1 && k == FD / 2 + 1) ? ~v : v;
        @(negedge CLK);
      end
    end
  endtask

  initial begin
    int         s0, s1, busy_cnt, nv_before, t;
    logic [7:0] pat;
    @(negedge CLK);
    hold(4);
    RST = 1'b0;
    hold(10);
    check("reset_data", 32'(RX_DATA), 32'h00);
    check("reset_busy", 32'(RX_BUSY), 32'(0));

    // 0x55, one clean frame.
    send_frame(8'h55, 1'b1, 0, s0);
    hold(20);
    check("data_55", 32'(RX_DATA), 32'h55);
    check("valid_count_55", 32'(n_valid), 32'(1));
    check("latency_55", 32'(last_valid_cyc - s0), 32'(4126 + MAJ));

    // 100-cycle low glitch on an idle line.
    busy_cnt = 0;
    RX_PIN = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i == 100) RX_PIN = 1'b1;
      @(negedge CLK);
      if (RX_BUSY === 1'b1) busy_cnt++;
    end
    check("glitch_busy_cycles", 32'(busy_cnt), 32'(217 + MAJ));
    check("glitch_no_valid", 32'(n_valid), 32'(1));
    check("glitch_no_err", 32'(n_err), 32'(0));
    check("glitch_busy_end", 32'(RX_BUSY), 32'(0));

    // 0xA5 with a 2000-cycle low stop bit, then 0x3C.
    send_frame(8'hA5, 1'b0, 2000, s0);
    check("break_err_count", 32'(n_err), 32'(1));
    check("break_keeps_data", 32'(RX_DATA), 32'h55);
    send_frame(8'h3C, 1'b1, 0, s0);
    hold(20);
    check("data_3c", 32'(RX_DATA), 32'h3C);
    check("valid_count_3c", 32'(n_valid), 32'(2));

    // 0x00 and 0xFF with no idle gap.
    send_frame(8'h00, 1'b1, 0, s0);
    send_frame(8'hFF, 1'b1, 0, s1);
    hold(20);
    check("b2b_valid_count", 32'(n_valid), 32'(4));
    check("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'(4340));
    check("b2b_data_ff", 32'(RX_DATA), 32'hFF);

    // Reset during bit 4 of 0x81, then 0x7E.
    pat = 8'h81;
    RX_PIN = 1'b0;
    hold(D);
    for (int i = 0; i < 4; i++) begin
      RX_PIN = pat[i];
      hold(D);
    end
    RX_PIN = pat[4];
    hold(D / 2);
    RST = 1'b1;
    RX_PIN = 1'b1;
    hold(4);
    RST = 1'b0;
    hold(50);
    check("midframe_reset_data", 32'(RX_DATA), 32'h00);
    check("midframe_reset_busy", 32'(RX_BUSY), 32'(0));
    nv_before = n_valid;
    send_frame(8'h7E, 1'b1, 0, s0);
    hold(20);
    check("after_reset_valids", 32'(n_valid - nv_before), 32'(1));
    check("data_7e", 32'(RX_DATA), 32'h7E);
    check("total_errs", 32'(n_err), 32'(1));

    // Full byte sweep on the short-divider instance.
    for (int b = 0; b < 256; b++) send_fast(8'(b));
    t = 0;
    while (f_n < 256 && t < 200) begin
      @(negedge CLK);
      t++;
    end
    check("sweep_count", 32'(f_n), 32'(256));
    check("sweep_errs", 32'(f_nerr), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
